// File: rtl/order_stage_sequencer.sv
// Main-control sequencer for the 18-bit Order Tank: digit/minor timing, Stage 1/Stage 2 gating,
// order clear and SCT advance. Define ORDER_STAGE_SINGLE_STEP_EN to add the single-step HOLD state.
module order_stage_sequencer #(
    parameter int WORD_WIDTH       = 18,
    parameter int TANK_WORDS       = 16,
    parameter int LONG_EXEC_MINORS = 4
) (
    input  logic       clk,
    input  logic       reset_neg,
    input  logic       start,
    input  logic       stop_req,
    input  logic [3:0] sct_pos,
    input  logic [3:0] opnd_pos,
    input  logic       opnd_valid,
    input  logic       long_op,
    input  logic       step,
    output logic [4:0] digit,
    output logic [3:0] minor,
    output logic       g12,
    output logic       g13,
    output logic       cu_gate_pos,
    output logic       order_clr,
    output logic       sct_inc,
    output logic       running
);

    if (WORD_WIDTH < 2 || WORD_WIDTH > 32) begin : g_bad_word_width
        $error("order_stage_sequencer: WORD_WIDTH must be in 2..32");
    end
    if (TANK_WORDS < 2 || TANK_WORDS > 16) begin : g_bad_tank_words
        $error("order_stage_sequencer: TANK_WORDS must be in 2..16");
    end
    if (LONG_EXEC_MINORS < 2 || LONG_EXEC_MINORS > 15) begin : g_bad_long_exec
        $error("order_stage_sequencer: LONG_EXEC_MINORS must be in 2..15");
    end

    localparam logic [4:0] DIGIT_LAST = 5'(WORD_WIDTH - 1);
    localparam logic [3:0] MINOR_LAST = 4'(TANK_WORDS - 1);
    localparam logic [3:0] EXEC_LONG  = 4'(LONG_EXEC_MINORS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_S1_WAIT = 3'd1,
        ST_S1_XFER = 3'd2,
        ST_S2_WAIT = 3'd3,
        ST_S2_EXEC = 3'd4,
        ST_CLEAR   = 3'd5
`ifdef ORDER_STAGE_SINGLE_STEP_EN
        , ST_HOLD  = 3'd6
`endif
    } state_t;

    logic [4:0] r_digit;
    logic [3:0] r_minor;
    state_t     r_state;
    logic       r_stop;
    logic [3:0] r_exec;

    logic       w_boundary;
    logic [3:0] w_nxt_minor;
    logic [4:0] w_digit_next;
    logic [3:0] w_minor_next;
    state_t     w_state_next;
    logic       w_stop_next;
    logic [3:0] w_exec_next;

`ifdef ORDER_STAGE_SINGLE_STEP_EN
    logic       r_step;
    logic       w_step_next;
`else
    logic       w_unused_step;
    assign w_unused_step = step;
`endif

    assign w_boundary   = (r_digit == DIGIT_LAST);
    assign w_nxt_minor  = (r_minor == MINOR_LAST) ? 4'd0 : r_minor + 4'd1;
    assign w_digit_next = w_boundary ? 5'd0 : r_digit + 5'd1;
    assign w_minor_next = w_boundary ? w_nxt_minor : r_minor;

    always_comb begin
        w_state_next = r_state;
        w_exec_next  = r_exec;
        w_stop_next  = r_stop;
`ifdef ORDER_STAGE_SINGLE_STEP_EN
        w_step_next  = r_step;
`endif
        // A stop only takes effect once the current order has been cleared.
        if (r_state != ST_IDLE && stop_req)
            w_stop_next = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_state_next = ST_S1_WAIT;
            end
            ST_S1_WAIT: begin
                if (w_boundary && w_nxt_minor == sct_pos)
                    w_state_next = ST_S1_XFER;
            end
            ST_S1_XFER: begin
                if (w_boundary)
                    w_state_next = ST_S2_WAIT;
            end
            ST_S2_WAIT: begin
                if (w_boundary && opnd_valid && w_nxt_minor == opnd_pos) begin
                    w_state_next = ST_S2_EXEC;
                    w_exec_next  = long_op ? EXEC_LONG : 4'd1;
                end
            end
            ST_S2_EXEC: begin
                if (w_boundary) begin
                    if (r_exec == 4'd1) begin
                        w_state_next = ST_CLEAR;
                        w_exec_next  = 4'd0;
                    end else begin
                        w_exec_next  = r_exec - 4'd1;
                    end
                end
            end
            ST_CLEAR: begin
                if (w_boundary) begin
                    if (r_stop || stop_req) begin
                        w_state_next = ST_IDLE;
                        w_stop_next  = 1'b0;
                    end else begin
`ifdef ORDER_STAGE_SINGLE_STEP_EN
                        w_state_next = ST_HOLD;
`else
                        w_state_next = ST_S1_WAIT;
`endif
                    end
                end
            end
`ifdef ORDER_STAGE_SINGLE_STEP_EN
            ST_HOLD: begin
                w_step_next = r_step || step;
                if (w_boundary) begin
                    if (r_stop || stop_req) begin
                        w_state_next = ST_IDLE;
                        w_stop_next  = 1'b0;
                        w_step_next  = 1'b0;
                    end else if (r_step || step) begin
                        w_state_next = ST_S1_WAIT;
                        w_step_next  = 1'b0;
                    end
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            r_digit     <= 5'd0;
            r_minor     <= 4'd0;
            r_state     <= ST_IDLE;
            r_stop      <= 1'b0;
            r_exec      <= 4'd0;
`ifdef ORDER_STAGE_SINGLE_STEP_EN
            r_step      <= 1'b0;
`endif
            g12         <= 1'b0;
            g13         <= 1'b0;
            cu_gate_pos <= 1'b0;
            order_clr   <= 1'b0;
            sct_inc     <= 1'b0;
            running     <= 1'b0;
        end else begin
            r_digit     <= w_digit_next;
            r_minor     <= w_minor_next;
            r_state     <= w_state_next;
            r_stop      <= w_stop_next;
            r_exec      <= w_exec_next;
`ifdef ORDER_STAGE_SINGLE_STEP_EN
            r_step      <= w_step_next;
`endif
            g12         <= (w_state_next == ST_S1_WAIT) || (w_state_next == ST_S1_XFER);
            g13         <= (w_state_next == ST_S2_WAIT) || (w_state_next == ST_S2_EXEC) ||
                           (w_state_next == ST_CLEAR);
            cu_gate_pos <= (w_state_next == ST_S1_XFER) || (w_state_next == ST_S2_EXEC);
            order_clr   <= (w_state_next == ST_CLEAR);
            sct_inc     <= (w_state_next == ST_CLEAR) && (w_digit_next == DIGIT_LAST);
            running     <= (w_state_next != ST_IDLE);
        end
    end

    assign digit = r_digit;
    assign minor = r_minor;

endmodule

// File: tb/tb_order_stage_sequencer.sv
// Bench for order_stage_sequencer: order streams are scheduled with minor-cycle arithmetic
// and the expected output of every clock is queued for a decoupled monitor.
module tb_order_stage_sequencer;

    localparam int WW  = 18;
    localparam int TW  = 16;
    localparam int LEM = 4;

    logic       clk        = 1'b0;
    logic       reset_neg  = 1'b0;
    logic       start      = 1'b0;
    logic       stop_req   = 1'b0;
    logic [3:0] sct_pos    = 4'd0;
    logic [3:0] opnd_pos   = 4'd0;
    logic       opnd_valid = 1'b0;
    logic       long_op    = 1'b0;
    logic       step       = 1'b0;
    logic [4:0] digit;
    logic [3:0] minor;
    logic       g12, g13, cu_gate_pos, order_clr, sct_inc, running;

    order_stage_sequencer #(
        .WORD_WIDTH      (WW),
        .TANK_WORDS      (TW),
        .LONG_EXEC_MINORS(LEM)
    ) dut (
        .clk        (clk),
        .reset_neg  (reset_neg),
        .start      (start),
        .stop_req   (stop_req),
        .sct_pos    (sct_pos),
        .opnd_pos   (opnd_pos),
        .opnd_valid (opnd_valid),
        .long_op    (long_op),
        .step       (step),
        .digit      (digit),
        .minor      (minor),
        .g12        (g12),
        .g13        (g13),
        .cu_gate_pos(cu_gate_pos),
        .order_clr  (order_clr),
        .sct_inc    (sct_inc),
        .running    (running)
    );

    always #5 clk = ~clk;

    // One order: s = edge entering Stage 1, mx = absolute minor of the fetch transfer,
    // e = first execute minor, n = execute length, clr = edge leaving CLEAR.
    typedef struct {
        int s;
        int sct;
        int opnd;
        bit lng;
        int ve;
        int mx;
        int e;
        int n;
        int clr;
    } order_t;

    order_t      ord[4];
    int          n_ord = 1;
    int          cfg_sct[4];
    int          cfg_opnd[4];
    int          cfg_vdly[4];
    bit          cfg_lng[4];
    logic [14:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cur_edge = 0;

    function automatic logic [14:0] outvec();
        return {digit, minor, g12, g13, cu_gate_pos, order_clr, sct_inc, running};
    endfunction

    task automatic check_vec(input string name, input logic [14:0] got, input logic [14:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s @%0t: got digit=%0d minor=%0d g12/g13/cu/clr/inc/run=%b, want digit=%0d minor=%0d g12/g13/cu/clr/inc/run=%b",
                     name, $time, got[14:10], got[9:6], got[5:0], want[14:10], want[9:6], want[5:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Smallest absolute minor >= from_m that sits at tank position pos.
    function automatic int next_at(input int from_m, input int pos);
        int m;
        m = from_m;
        while (m % TW != pos) m++;
        return m;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Expected outputs after edge x, read off the order schedule.
    function automatic logic [14:0] expect_at(input int x);
        int   m, d, k;
        logic a12, a13, acu, aclr, ainc, arun;
        d = x % WW;
        m = x / WW;
        {a12, a13, acu, aclr, ainc, arun} = 6'b0;
        if (x >= ord[0].s && x < ord[n_ord-1].clr) begin
            k = 0;
            for (int j = 1; j < n_ord; j++)
                if (x >= ord[j].s) k = j;
            arun = 1'b1;
            if (m < ord[k].mx) begin
                a12 = 1'b1;
            end else if (m == ord[k].mx) begin
                a12 = 1'b1;
                acu = 1'b1;
            end else if (m < ord[k].e) begin
                a13 = 1'b1;
            end else if (m < ord[k].e + ord[k].n) begin
                a13 = 1'b1;
                acu = 1'b1;
            end else begin
                a13  = 1'b1;
                aclr = 1'b1;
                ainc = (d == WW - 1);
            end
        end
        return {5'(d), 4'(m % TW), a12, a13, acu, aclr, ainc, arun};
    endfunction

    task automatic plan(input int ts, input int nord);
        int s;
        s = ts;
        n_ord = nord;
        for (int k = 0; k < nord; k++) begin
            ord[k].s    = s;
            ord[k].sct  = cfg_sct[k];
            ord[k].opnd = cfg_opnd[k];
            ord[k].lng  = cfg_lng[k];
            ord[k].mx   = next_at(s / WW + 1, cfg_sct[k]);
            ord[k].ve   = (ord[k].mx + 1) * WW + cfg_vdly[k];
            ord[k].e    = next_at(imax(ord[k].mx + 2, (ord[k].ve + WW - 1) / WW), cfg_opnd[k]);
            ord[k].n    = cfg_lng[k] ? LEM : 1;
            ord[k].clr  = (ord[k].e + ord[k].n + 1) * WW;
            s = ord[k].clr;
        end
    endtask

    task automatic hold_reset();
        reset_neg  = 1'b0;
        start      = 1'b0;
        stop_req   = 1'b0;
        opnd_valid = 1'b0;
        long_op    = 1'b0;
        step       = 1'b0;
        #1;
        check_vec("reset_async", outvec(), 15'd0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(15'd0);
            @(negedge clk);
            #1;
        end
        reset_neg = 1'b1;
        cur_edge  = 0;
    endtask

    // stop_mode: 0 anywhere in the last order, 1 during its Stage 2 wait, 2 on its CLEAR boundary.
    task automatic run_episode(input int nord, input int start_minor, input int stop_mode, input bit rst_exec);
        int ts, stop_e, idle_stop, dup_start, last_clr, rst_x, k, lo;
        if (start_minor < 0) begin
            ts = cur_edge + 2 + int'($urandom_range(0, 60));
        end else begin
            ts = cur_edge + 2;
            while ((ts / WW) % TW != start_minor) ts++;
            ts = ts + int'($urandom_range(0, WW - 1 - ts % WW));
        end
        plan(ts, nord);
        last_clr = ord[nord-1].clr;
        case (stop_mode)
            0: stop_e = int'($urandom_range(ord[nord-1].s + 1, last_clr));
            1: begin
                lo     = (ord[nord-1].mx + 1) * WW + 1;
                stop_e = int'($urandom_range(lo, ord[nord-1].e * WW));
            end
            default: stop_e = last_clr;
        endcase
        idle_stop = int'($urandom_range(cur_edge + 1, ts));
        dup_start = int'($urandom_range(ts + 1, last_clr));
        rst_x     = rst_exec ? ord[0].e * WW + 7 : -1;
        for (int x = cur_edge + 1; x <= last_clr + 20; x++) begin
            k = 0;
            for (int j = 1; j < nord; j++)
                if (x > ord[j].s) k = j;
            start      = (x == ts) || (x == dup_start);
            stop_req   = (x == stop_e) || (x == idle_stop);
            sct_pos    = 4'(ord[k].sct);
            opnd_pos   = 4'(ord[k].opnd);
            long_op    = ord[k].lng;
            opnd_valid = (x >= ord[k].ve) && (x <= ord[k].clr);
            step       = 1'($urandom_range(0, 1));
            exp_q.push_back(expect_at(x));
            @(negedge clk);
            #1;
            cur_edge = x;
            if (x == rst_x) begin
                hold_reset();
                return;
            end
        end
    endtask

    task automatic monitor_loop();
        logic [14:0] want;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check_vec("cycle_outputs", outvec(), want);
            end
        end
    endtask

    task automatic randomize_cfg(input int nord);
        for (int k = 0; k < nord; k++) begin
            cfg_sct[k]  = int'($urandom_range(0, TW - 1));
            cfg_opnd[k] = int'($urandom_range(0, TW - 1));
            cfg_lng[k]  = 1'($urandom_range(0, 1));
            cfg_vdly[k] = int'($urandom_range(0, 60));
        end
    endtask

    initial begin
        int nord;
        fork
            monitor_loop();
        join_none

        @(negedge clk);
        #1;
        hold_reset();

        // Fetch at minor 5, short execute at 9, then a second order.
        randomize_cfg(2);
        cfg_sct[0] = 5; cfg_opnd[0] = 9; cfg_lng[0] = 1'b0; cfg_vdly[0] = 0;
        run_episode(2, 2, 0, 1'b0);

        // Long execute wrapping through minor 0; stop lands on the CLEAR boundary.
        randomize_cfg(1);
        cfg_opnd[0] = 14; cfg_lng[0] = 1'b1; cfg_vdly[0] = 0;
        run_episode(1, -1, 2, 1'b0);

        // Fetch position equal to the start minor waits a full major cycle; stop during Stage 2 wait.
        randomize_cfg(1);
        cfg_sct[0] = 3; cfg_lng[0] = 1'b0;
        run_episode(1, 3, 1, 1'b0);

        // Reset asserted at digit 7 of the first execute minor.
        randomize_cfg(1);
        cfg_lng[0] = 1'b1;
        run_episode(1, -1, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            nord = int'($urandom_range(1, 3));
            randomize_cfg(nord);
            run_episode(nord, -1, int'($urandom_range(0, 2)), 1'b0);
        end

        check_int("queue_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
